// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the 5-stage core pipeline controller.
//   RA_W            : register address width
//   FWD_REG/W/M     : execute-stage operand select encodings
//   stage_t         : shadow destination-register record kept per stage
package pipe_pkg;

  localparam int RA_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W   = 2'b01;  // operand from writeback result
  localparam logic [1:0] FWD_M   = 2'b10;  // operand from memory-stage ALU result

  typedef struct packed {
    logic [RA_W-1:0] rd;  // destination register
    logic            wr;  // instruction writes rd
    logic            ld;  // instruction is a load
  } stage_t;

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if -- bundle between the pipeline datapath and the hazard unit.
//   master : datapath side, drives decode info and takenE, receives controls
//   slave  : hazard unit side
//   D-stage info : rs1D, rs2D, rdD, useRs1D, useRs2D, RegWriteD, MemtoRegD
//   E-stage info : takenE (branch/jump resolved taken)
//   controls     : stallF, stallD, flushD, flushE, forwardAE/BE, forwardAD/BD
//   counters     : stall_cnt, flush_cnt
interface hazard_unit_if #(
  parameter int RA_W  = pipe_pkg::RA_W,
  parameter int CNT_W = 32
);
  logic [RA_W-1:0]  rs1D;
  logic [RA_W-1:0]  rs2D;
  logic [RA_W-1:0]  rdD;
  logic             useRs1D;
  logic             useRs2D;
  logic             RegWriteD;
  logic             MemtoRegD;
  logic             takenE;
  logic             stallF;
  logic             stallD;
  logic             flushD;
  logic             flushE;
  logic [1:0]       forwardAE;
  logic [1:0]       forwardBE;
  logic             forwardAD;
  logic             forwardBD;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1D, rs2D, rdD, useRs1D, useRs2D, RegWriteD, MemtoRegD, takenE,
    input  stallF, stallD, flushD, flushE, forwardAE, forwardBE,
           forwardAD, forwardBD, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1D, rs2D, rdD, useRs1D, useRs2D, RegWriteD, MemtoRegD, takenE,
    output stallF, stallD, flushD, flushE, forwardAE, forwardBE,
           forwardAD, forwardBD, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_match.sv
// hazard_match -- register dependency comparator.
//   addr  : source register being read
//   rd    : destination register of an older in-flight instruction
//   wr    : that instruction writes rd
//   match : dependency exists; x0 is hard-wired zero and never matches
module hazard_match #(
  parameter int W = pipe_pkg::RA_W
) (
  input  logic [W-1:0] addr,
  input  logic [W-1:0] rd,
  input  logic         wr,
  output logic         match
);

  assign match = wr && (rd != '0) && (rd == addr);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit -- central stall/flush/forward controller for the F/D/E/M/W core.
//   clk, rst : clock, asynchronous active-high reset
//   hz       : hazard_unit_if.slave (decode info in, pipeline controls and
//              saturating stall/flush event counters out)
// Tracks destination-register info for E, M and W in a shadow pipeline and
// derives all controls combinationally from it and the decode inputs.
// Build option HAZARD_FORWARD_EN: enables E-stage forwarding from M and W;
// only load-use then stalls. Without it, any RAW dependency on E or M stalls
// until the producer reaches W, where the D-stage bypass covers it.
module hazard_unit #(
  parameter int RA_W  = pipe_pkg::RA_W,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  hazard_unit_if.slave hz
);

  // comparator slots: D operands against E/M/W, E operands against M/W
  localparam int H_D1E = 0;
  localparam int H_D2E = 1;
  localparam int H_D1M = 2;
  localparam int H_D2M = 3;
  localparam int H_D1W = 4;
  localparam int H_D2W = 5;
`ifdef HAZARD_FORWARD_EN
  localparam int H_E1M = 6;
  localparam int H_E2M = 7;
  localparam int H_E1W = 8;
  localparam int H_E2W = 9;
  localparam int NM    = 10;
`else
  localparam int NM    = 6;
`endif

  pipe_pkg::stage_t e_q, e_d, m_q, m_d, w_q, w_d;
  logic [RA_W-1:0]  rs1e_q, rs1e_d, rs2e_q, rs2e_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic [RA_W-1:0] cmp_addr [NM];
  logic [RA_W-1:0] cmp_rd   [NM];
  logic [NM-1:0]   cmp_wr;
  logic [NM-1:0]   hit;

  logic stall_src;   // dependency that the pipeline must wait out
  logic stall_w;
  logic flush_e_w;

  // ---------------- comparator wiring ----------------
  always_comb begin
    cmp_addr[H_D1E] = hz.rs1D;  cmp_rd[H_D1E] = e_q.rd;  cmp_wr[H_D1E] = e_q.wr;
    cmp_addr[H_D2E] = hz.rs2D;  cmp_rd[H_D2E] = e_q.rd;  cmp_wr[H_D2E] = e_q.wr;
    cmp_addr[H_D1M] = hz.rs1D;  cmp_rd[H_D1M] = m_q.rd;  cmp_wr[H_D1M] = m_q.wr;
    cmp_addr[H_D2M] = hz.rs2D;  cmp_rd[H_D2M] = m_q.rd;  cmp_wr[H_D2M] = m_q.wr;
    cmp_addr[H_D1W] = hz.rs1D;  cmp_rd[H_D1W] = w_q.rd;  cmp_wr[H_D1W] = w_q.wr;
    cmp_addr[H_D2W] = hz.rs2D;  cmp_rd[H_D2W] = w_q.rd;  cmp_wr[H_D2W] = w_q.wr;
`ifdef HAZARD_FORWARD_EN
    cmp_addr[H_E1M] = rs1e_q;   cmp_rd[H_E1M] = m_q.rd;  cmp_wr[H_E1M] = m_q.wr;
    cmp_addr[H_E2M] = rs2e_q;   cmp_rd[H_E2M] = m_q.rd;  cmp_wr[H_E2M] = m_q.wr;
    cmp_addr[H_E1W] = rs1e_q;   cmp_rd[H_E1W] = w_q.rd;  cmp_wr[H_E1W] = w_q.wr;
    cmp_addr[H_E2W] = rs2e_q;   cmp_rd[H_E2W] = w_q.rd;  cmp_wr[H_E2W] = w_q.wr;
`endif
  end

  for (genvar gi = 0; gi < NM; gi++) begin : g_match
    hazard_match #(.W(RA_W)) u_match (
      .addr  (cmp_addr[gi]),
      .rd    (cmp_rd[gi]),
      .wr    (cmp_wr[gi]),
      .match (hit[gi])
    );
  end

  // ---------------- hazard detection ----------------
  always_comb begin
    stall_src = 1'b0;
`ifdef HAZARD_FORWARD_EN
    // only a load in E cannot be forwarded in time
    stall_src = e_q.ld && ((hz.useRs1D && hit[H_D1E]) || (hz.useRs2D && hit[H_D2E]));
`else
    // no E forwarding: wait until the producer reaches W (covered by D bypass)
    stall_src = (hz.useRs1D && (hit[H_D1E] || hit[H_D1M])) ||
                (hz.useRs2D && (hit[H_D2E] || hit[H_D2M]));
`endif
    // a taken branch discards the stalled instruction, so the redirect wins
    stall_w   = stall_src && !hz.takenE;
    flush_e_w = stall_src || hz.takenE;
  end

  // ---------------- control outputs ----------------
  always_comb begin
    hz.stallF    = stall_w;
    hz.stallD    = stall_w;
    hz.flushD    = hz.takenE;
    hz.flushE    = flush_e_w;
    hz.forwardAD = hit[H_D1W];
    hz.forwardBD = hit[H_D2W];
    hz.forwardAE = pipe_pkg::FWD_REG;
    hz.forwardBE = pipe_pkg::FWD_REG;
`ifdef HAZARD_FORWARD_EN
    // M has priority as the younger producer; a load in M has no ALU result
    if (hit[H_E1M] && !m_q.ld)  hz.forwardAE = pipe_pkg::FWD_M;
    else if (hit[H_E1W])        hz.forwardAE = pipe_pkg::FWD_W;
    if (hit[H_E2M] && !m_q.ld)  hz.forwardBE = pipe_pkg::FWD_M;
    else if (hit[H_E2W])        hz.forwardBE = pipe_pkg::FWD_W;
`endif
    hz.stall_cnt = stall_cnt_q;
    hz.flush_cnt = flush_cnt_q;
  end

  // ---------------- shadow pipeline and counters, next state ----------------
  always_comb begin
    e_d    = '0;
    rs1e_d = '0;
    rs2e_d = '0;
    if (!flush_e_w) begin
      e_d.rd = hz.rdD;
      e_d.wr = hz.RegWriteD;
      e_d.ld = hz.MemtoRegD;
      rs1e_d = hz.rs1D;
      rs2e_d = hz.rs2D;
    end
    m_d = e_q;
    w_d = m_q;

    stall_cnt_d = stall_cnt_q;
    if (stall_w && !(&stall_cnt_q))      stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (hz.takenE && !(&flush_cnt_q))    flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      rs1e_q      <= '0;
      rs2e_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      rs1e_q      <= rs1e_d;
      rs2e_q      <= rs2e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // shadow fields that this build does not consume
  logic unused_sink;
`ifdef HAZARD_FORWARD_EN
  assign unused_sink = ^{w_q.ld, hit[H_D1M], hit[H_D2M]};
`else
  assign unused_sink = ^{w_q.ld, m_q.ld, e_q.ld, rs1e_q, rs2e_q};
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit -- directed self-checking bench for hazard_unit.
// Output vector order: {stallF, stallD, flushD, flushE, forwardAE, forwardBE,
// forwardAD, forwardBD}. Build option HAZARD_FORWARD_EN selects expectations.
module tb_hazard_unit;

  logic clk;
  logic rst;

  hazard_unit_if #(.RA_W(5), .CNT_W(32)) hz();

  hazard_unit #(.RA_W(5), .CNT_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] outs;
  assign outs = {hz.stallF, hz.stallD, hz.flushD, hz.flushE,
                 hz.forwardAE, hz.forwardBE, hz.forwardAD, hz.forwardBD};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;
  logic [9:0]  exp_o;

  localparam logic [9:0] O_NONE   = 10'b0000_00_00_00;
  localparam logic [9:0] O_STALL  = 10'b1101_00_00_00;
  localparam logic [9:0] O_TAKEN  = 10'b0011_00_00_00;
  localparam logic [9:0] O_FAD    = 10'b0000_00_00_10;
  localparam logic [9:0] O_FADBD  = 10'b0000_00_00_11;
  localparam logic [9:0] O_FAE_W  = 10'b0000_01_00_00;
  localparam logic [9:0] O_FAE_M  = 10'b0000_10_00_00;

  // drive the D-stage instruction and takenE, then let outputs settle
  task automatic set_d(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic wr, input logic ld,
                       input logic tk);
    hz.rs1D = r1; hz.rs2D = r2; hz.rdD = rd;
    hz.useRs1D = u1; hz.useRs2D = u2; hz.RegWriteD = wr; hz.MemtoRegD = ld;
    hz.takenE = tk;
    #1;
    $display("[%0t] D rs1=x%0d rs2=x%0d rd=x%0d use=%b%b wr=%b ld=%b taken=%b -> outs=%b scnt=%0d fcnt=%0d",
             $time, r1, r2, rd, u1, u2, wr, ld, tk, outs, hz.stall_cnt, hz.flush_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (3) begin
      set_d(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    exp_stall = 0; exp_flush = 0;
    n_checks++;
    if (outs !== O_NONE) begin n_fail++; $display("FAIL reset_outs got=%b want=%b", outs, O_NONE); end
    n_checks++;
    if (hz.stall_cnt !== exp_stall || hz.flush_cnt !== exp_flush) begin
      n_fail++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", hz.stall_cnt, hz.flush_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

`ifndef HAZARD_FORWARD_EN
  // add x5,x1,x2 ; sub x8,x5,x4 -> two stall cycles, then D bypass
  task automatic test_raw_stall();
    set_d(1, 2, 5, 1, 1, 1, 0, 0);
    exp_o = O_NONE; n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL raw_add got=%b want=%b", outs, exp_o); end
    tick();
    for (int i = 0; i < 2; i++) begin
      set_d(5, 4, 8, 1, 1, 1, 0, 0);
      exp_o = O_STALL; n_checks++;
      if (outs !== exp_o) begin n_fail++; $display("FAIL raw_stall%0d got=%b want=%b", i, outs, exp_o); end
      exp_stall++;
      tick();
    end
    set_d(5, 4, 8, 1, 1, 1, 0, 0);
    exp_o = O_FAD; n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL raw_bypass got=%b want=%b", outs, exp_o); end
    n_checks++;
    if (hz.stall_cnt !== exp_stall) begin n_fail++; $display("FAIL raw_cnt got=%0d want=%0d", hz.stall_cnt, exp_stall); end
    tick();
    drain();
  endtask
`else
  // add x5 then dependent add: M forwarding; with a gap: W forwarding
  task automatic test_forward_m();
    set_d(1, 2, 5, 1, 1, 1, 0, 0); tick();
    set_d(5, 3, 6, 1, 1, 1, 0, 0);
    exp_o = O_NONE; n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL fwd_nostall got=%b want=%b", outs, exp_o); end
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    exp_o = O_FAE_M; n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL fwd_m got=%b want=%b", outs, exp_o); end
    tick();
    drain();
    set_d(1, 2, 5, 1, 1, 1, 0, 0); tick();
    set_d(1, 1, 9, 1, 1, 1, 0, 0); tick();
    set_d(5, 3, 6, 1, 1, 1, 0, 0); tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    exp_o = O_FAE_W; n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL fwd_w got=%b want=%b", outs, exp_o); end
    tick();
    drain();
  endtask
`endif

  // lw x6,0(x1) ; add x7,x6,x2
  task automatic test_load_use();
    set_d(1, 0, 6, 1, 0, 1, 1, 0); tick();
    set_d(6, 2, 7, 1, 1, 1, 0, 0);
    exp_o = O_STALL; n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL lu_stall got=%b want=%b", outs, exp_o); end
    exp_stall++;
    tick();
    set_d(6, 2, 7, 1, 1, 1, 0, 0);
`ifdef HAZARD_FORWARD_EN
    exp_o = O_NONE;
`else
    exp_o = O_STALL;
    exp_stall++;
`endif
    n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL lu_second got=%b want=%b", outs, exp_o); end
    tick();
`ifdef HAZARD_FORWARD_EN
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    exp_o = O_FAE_W;
`else
    set_d(6, 2, 7, 1, 1, 1, 0, 0);
    exp_o = O_FAD;
`endif
    n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL lu_fwd got=%b want=%b", outs, exp_o); end
    n_checks++;
    if (hz.stall_cnt !== exp_stall) begin n_fail++; $display("FAIL lu_cnt got=%0d want=%0d", hz.stall_cnt, exp_stall); end
    tick();
    drain();
  endtask

  // load-use hazard coinciding with a taken branch, then a lone taken branch
  task automatic test_branch_collision();
    set_d(1, 0, 6, 1, 0, 1, 1, 0); tick();
    set_d(6, 2, 7, 1, 1, 1, 0, 1);
    exp_o = O_TAKEN; n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL br_collide got=%b want=%b", outs, exp_o); end
    exp_flush++;
    tick();
    n_checks++;
    if (hz.flush_cnt !== exp_flush || hz.stall_cnt !== exp_stall) begin
      n_fail++; $display("FAIL br_cnt got=%0d/%0d want=%0d/%0d", hz.flush_cnt, hz.stall_cnt, exp_flush, exp_stall);
    end
    drain();
    set_d(0, 0, 0, 0, 0, 0, 0, 1);
    exp_o = O_TAKEN; n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL br_plain got=%b want=%b", outs, exp_o); end
    exp_flush++;
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (hz.flush_cnt !== exp_flush) begin n_fail++; $display("FAIL br_plain_cnt got=%0d want=%0d", hz.flush_cnt, exp_flush); end
    drain();
  endtask

  // x0 writer never creates a hazard; x9 writer three ahead uses D bypass
  task automatic test_x0_and_bypass();
    set_d(1, 0, 0, 1, 0, 1, 0, 0); tick();
    set_d(0, 0, 3, 1, 1, 1, 0, 0);
    exp_o = O_NONE; n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL x0_d got=%b want=%b", outs, exp_o); end
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL x0_e got=%b want=%b", outs, exp_o); end
    tick();
    drain();
    set_d(1, 0, 9, 1, 0, 1, 0, 0); tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_d(9, 9, 10, 1, 1, 1, 0, 0);
    exp_o = O_FADBD; n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL bypass_x9 got=%b want=%b", outs, exp_o); end
    tick();
    drain();
  endtask

  // asynchronous reset while a load-use stall is pending
  task automatic test_reset_mid();
    set_d(1, 0, 6, 1, 0, 1, 1, 0); tick();
    set_d(6, 2, 7, 1, 1, 1, 0, 0);
    exp_o = O_STALL; n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL rm_pre got=%b want=%b", outs, exp_o); end
    rst = 1'b1;
    #1;
    exp_stall = 0; exp_flush = 0;
    n_checks++;
    if (outs !== O_NONE) begin n_fail++; $display("FAIL rm_outs got=%b want=%b", outs, O_NONE); end
    n_checks++;
    if (hz.stall_cnt !== exp_stall || hz.flush_cnt !== exp_flush) begin
      n_fail++; $display("FAIL rm_cnt got=%0d/%0d want=0/0", hz.stall_cnt, hz.flush_cnt);
    end
    tick();
    rst = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 1);
    exp_o = O_TAKEN; n_checks++;
    if (outs !== exp_o) begin n_fail++; $display("FAIL rm_after got=%b want=%b", outs, exp_o); end
    exp_flush++;
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (hz.flush_cnt !== exp_flush || hz.stall_cnt !== exp_stall) begin
      n_fail++; $display("FAIL rm_after_cnt got=%0d/%0d want=%0d/%0d", hz.flush_cnt, hz.stall_cnt, exp_flush, exp_stall);
    end
  endtask

  initial begin
    test_reset();
`ifdef HAZARD_FORWARD_EN
    test_forward_m();
`else
    test_raw_stall();
`endif
    test_load_use();
    test_branch_collision();
    test_x0_and_bypass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Central pipeline controller for the 5-stage core (F/D/E/M/W).
- Keeps a shadow pipeline of destination-register info for the E, M and W stages.
- Drives stall, flush and forwarding selects to the fetch, decode and execute stages.
- Resolves load-use and taken-branch hazards, and the W→D register-file collision (the register file has no internal bypass).
- Keeps performance counters for stall and flush events.

Parameters:
RA_W, 5, register address width
CNT_W, 32, perf counter width (saturating)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
rs1D  input  RA_W  instrD[19:15]
rs2D  input  RA_W  instrD[24:20]
rdD  input  RA_W  instrD[11:7]
useRs1D  input  1  D instruction reads rs1
useRs2D  input  1  D instruction reads rs2
RegWriteD  input  1  D instruction writes rd
MemtoRegD  input  1  D instruction is a load
takenE  input  1  branch/jump in E resolved taken (PC redirect this cycle)
stallF  output  1  hold PC
stallD  output  1  hold F/D register
flushD  output  1  clear F/D register
flushE  output  1  load bubble into D/E register
forwardAE  output  2  E operand A select: 00 reg, 01 resultW, 10 ALU result M
forwardBE  output  2  E operand B select, same encoding
forwardAD  output  1  D operand A uses resultW
forwardBD  output  1  D operand B uses resultW
stall_cnt  output  CNT_W  cycles with stallD=1
flush_cnt  output  CNT_W  cycles with takenE=1

Behaviour:
- Shadow state per stage S∈{E,M,W}: rdS, wrS, ldS. E also holds rs1E, rs2E.
- Reset (async): all shadow fields 0, both counters 0. With D inputs at 0, every output is 0.
- Shadow update each posedge:
  - E ← D info, or a bubble (wr=ld=0, rs=0) when flushE=1.
  - M ← E; W ← M. M and W always advance.
- Hazard logic is combinational from shadow state and D inputs, with 0-cycle latency. Outputs are not registered.
- Rule hit(a,S) = wrS && rdS!=0 && rdS==a. x0 never produces a hazard.
- forwardAD = hit(rs1D,W); forwardBD = hit(rs2D,W). These are active in both builds.
- lwstall = ldE && ((useRs1D && hit(rs1D,E)) || (useRs2D && hit(rs2D,E))).
- Normal priority:
  - stallF = stallD = lwstall && !takenE.
  - flushE = lwstall || takenE.
  - flushD = takenE.
- takenE together with lwstall: flush wins. stallF=stallD=0, flushD=flushE=1, and PC redirect proceeds.
- Counters increment by 1 per qualifying cycle and saturate at all-ones. Reset mid-operation clears them immediately.

Optional Feature:
HAZARD_FORWARD_EN
- Defined:
  - forwardAE = 10 if hit(rs1E,M) && !ldM; else 01 if hit(rs1E,W); else 00. forwardBE is the same using rs2E.
  - A load in M cannot forward; lwstall prevents that case.
- Undefined:
  - forwardAE = forwardBE = 00 always.
  - lwstall is replaced by rawstall = any used rs of D hitting E or M, for any writer type.
  - The W→D bypass still resolves the final cycle, so a back-to-back dependency stalls exactly 2 cycles.

Decomposition:
- Shared package pipe_pkg:
  - FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - Shadow-stage struct {rd, wr, ld}.
  - RA_W constant.
- One sub-module, hazard_match: the hit() comparator (addr, rd, wr → match). It is instantiated per operand/stage pair.

Test Plan:
1. Assert rst mid-stream with pending load in E → stall/flush/forward all 0 and stall_cnt=flush_cnt=0 immediately; after release, a fresh sequence behaves normally.
2. FORWARD_EN: add x5,x1,x2 then add x6,x5,x3 → next cycle forwardAE=10; with one independent instruction between them, forwardAE=01.
3. FORWARD_EN: lw x6,0(x1) then add x7,x6,x2 → one cycle stallF=stallD=flushE=1, then forwardAE=01; stall_cnt=1.
4. Load-use stall and takenE in the same cycle → stallF=0, flushD=flushE=1, flush_cnt+1, stall_cnt unchanged.
5. Writer to x0 followed by reader of x0 → no stall, all forwards 00; writer x9 three instructions ahead of a reader of x9 in D → forwardAD=1.
6. Without FORWARD_EN: add x5 then sub x8,x5,x4 → stallD=1 for exactly 2 cycles, then forwardAD=1 and forwardAE=00; stall_cnt=2.
